// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: accepts back-to-back writes, launches one byte per frame.
// Optional sticky overflow flag on output port overflow when UART_TX_QUEUE_OVERFLOW_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_start,
  output logic [7:0]        tx_data,
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  output logic              overflow,
`endif
  input  logic              tx_busy
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_WAIT_BUSY,
    Q_WAIT_DONE
  } state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              empty_reg;
  logic              full_reg;
  state_t            state_reg;
  logic              tx_start_reg;
  logic [7:0]        tx_data_reg;
  logic              push;
  logic              pop;

  // The full test uses the registered flag, so a write while full is dropped even if a pop coincides.
  assign push = wr_en && !full_reg;
  assign pop  = (state_reg == Q_IDLE) && !empty_reg && !tx_busy;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (ADDR_W + 1)'(1);
      2'b01:   count_next = count_reg - (ADDR_W + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == FULL_COUNT);
    end
  end

  // WAIT_BUSY absorbs the cycle between our pulse and the transmitter raising busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= Q_IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      tx_start_reg <= 1'b0;
      case (state_reg)
        Q_IDLE: begin
          if (pop) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= mem[rd_ptr_reg];
            state_reg    <= Q_WAIT_BUSY;
          end
        end
        Q_WAIT_BUSY: begin
          if (tx_busy) begin
            state_reg <= Q_WAIT_DONE;
          end
        end
        Q_WAIT_DONE: begin
          if (!tx_busy) begin
            state_reg <= Q_IDLE;
          end
        end
        default: state_reg <= Q_IDLE;
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && full_reg) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
`endif

  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a busy-timer transmitter stub and a launch monitor.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic       overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic       force_busy = 1'b0;
  int         busy_len = 10;
  int         busy_cnt = 0;
  logic [7:0] rxq [$];
  logic [7:0] expq [$];

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_start (tx_start),
    .tx_data  (tx_data),
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    .overflow (overflow),
`endif
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transmitter stub: busy rises the edge after it sees tx_start, stays high busy_len cycles.
  always @(posedge clk) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (tx_start && busy_cnt == 0) begin
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  // Launch monitor: records bytes, checks pulse width, busy overlap and relaunch gap.
  int   cyc = 0;
  logic start_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic fall_seen = 1'b0;
  logic fall_pending = 1'b0;
  int   fall_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (busy_prev && !tx_busy) begin
      fall_seen    = 1'b1;
      fall_pending = !empty;
      fall_cyc     = cyc;
    end
    if (tx_start) begin
      rxq.push_back(tx_data);
      $display("launch byte %02h at cycle %0d", tx_data, cyc);
      check("start_consecutive", start_prev, 0);
      check("start_while_busy", tx_busy, 0);
      if (fall_seen && fall_pending) begin
        check("launch_gap_le2", (cyc - fall_cyc) <= 2, 1);
      end
      fall_seen = 1'b0;
    end
    start_prev = tx_start;
    busy_prev  = tx_busy;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      tick();
      n++;
      if (empty && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    check({tag, "_drain_timeout"}, n >= 3000, 0);
  endtask

  initial begin
    int idx;
    int n;
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);

    // Single byte: launch two edges after the write
    rxq.delete();
    busy_len = 10;
    write(8'hA5);
    check("t1_count_after_wr", count, 1);
    check("t1_empty_after_wr", empty, 0);
    check("t1_no_start_yet", tx_start, 0);
    tick();
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_count_after_pop", count, 0);
    check("t1_empty_after_pop", empty, 1);
    tick();
    check("t1_start_one_cycle", tx_start, 0);
    drain("t1");
    check("t1_nbytes", rxq.size(), 1);
    if (rxq.size() == 1) check("t1_byte", rxq[0], 8'hA5);
    $display("txn single_write done");

    // Burst of 5 with long frames
    rxq.delete();
    busy_len = 20;
    for (int i = 1; i <= 5; i++) write(8'(i));
    drain("t2");
    check("t2_nbytes", rxq.size(), 5);
    for (int i = 0; i < 5 && i < rxq.size(); i++) check("t2_order", rxq[i], 32'(i + 1));
    $display("txn burst5 done");

    // Fill to full with busy held, 17th write dropped
    rxq.delete();
    busy_len = 3;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'h10 + 8'(i));
    check("t3_full", full, 1);
    check("t3_count16", count, 16);
    check("t3_not_empty", empty, 0);
    write(8'hFF);
    check("t3_count_after_drop", count, 16);
    check("t3_full_after_drop", full, 1);
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    check("t3_overflow_set", overflow, 1);
`endif
    force_busy = 1'b0;
    drain("t3");
    check("t3_nbytes", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++) check("t3_order", rxq[i], 32'(8'h10 + i));
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    check("t3_overflow_sticky", overflow, 1);
`endif
    $display("txn fill_full done");

    // Write at count=15 on the launch edge, then 40 bytes total through wrap
    rxq.delete();
    busy_len = 2;
    force_busy = 1'b1;
    for (int i = 0; i < 15; i++) write(8'h40 + 8'(i));
    check("t4_count15", count, 15);
    force_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h4F;
    tick();
    wr_en = 1'b0;
    check("t4_count_push_pop", count, 15);
    check("t4_start", tx_start, 1);
    check("t4_first_byte", tx_data, 8'h40);
    idx = 16;
    n = 0;
    while (idx < 40 && n < 2000) begin
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'h40 + 8'(idx);
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      n++;
    end
    wr_en = 1'b0;
    check("t4_write_timeout", n >= 2000, 0);
    drain("t4");
    check("t4_nbytes", rxq.size(), 40);
    for (int i = 0; i < 40 && i < rxq.size(); i++) check("t4_order", rxq[i], 32'(8'h40 + i));
    $display("txn wrap40 done");

    // Reset in WAIT_DONE with 3 queued
    rxq.delete();
    busy_len = 30;
    write(8'h50); write(8'h51); write(8'h52); write(8'h53);
    n = 0;
    while (!tx_busy && n < 100) begin tick(); n++; end
    check("t5_busy_timeout", n >= 100, 0);
    tick(); tick();
    check("t5_count3", count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_count", count, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_start", tx_start, 0);
    check("t5_rst_data", tx_data, 8'h00);
    for (int i = 0; i < 40; i++) tick();
    check("t5_no_flushed_launch", rxq.size(), 1);
    busy_len = 5;
    write(8'h3C);
    drain("t5");
    check("t5_nbytes", rxq.size(), 2);
    if (rxq.size() == 2) check("t5_new_byte", rxq[1], 8'h3C);
    $display("txn reset_mid_frame done");

    // Continuous wr_en with incrementing data, some dropped while full
    rxq.delete();
    expq.delete();
    busy_len = 4;
    wr_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wr_data = 8'(i);
      if (!full) expq.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    drain("t6");
    check("t6_nbytes", rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) check("t6_order", rxq[i], expq[i]);
    $display("txn continuous_write done, %0d accepted", expq.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
